// File: rtl/decim_fir.sv
`default_nettype none
// ============================================================================
// Module      : decim_fir
// Description : Decimate-by-DECIM 4-tap FIR, h = {+1/2, -1/2, -1/2, +1/2}.
//               Define DECIM_ROUND_EN for a single final round-half-up
//               instead of per-tap truncation toward zero.
// Revision    : 1.0  initial release
// ============================================================================
module decim_fir #(
    parameter int IN_W  = 15,
    parameter int OUT_W = 18,
    parameter int DECIM = 2,
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  xin,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out,
    output logic [PH_W-1:0]         phase
);

    localparam logic [PH_W-1:0] c_PH_LAST = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0] c_PH_ONE  = PH_W'(1);

    logic signed [IN_W-1:0]  r_d [4];
    logic [PH_W-1:0]         r_phase;
    logic signed [OUT_W-1:0] r_out;
    logic                    r_out_valid;

    // Delay line as it will look after this cycle's shift.
    logic signed [IN_W-1:0]  w_n [4];
    logic signed [OUT_W-1:0] w_x [4];
    logic signed [OUT_W-1:0] w_res;

    assign w_n[0] = xin;
    assign w_n[1] = r_d[0];
    assign w_n[2] = r_d[1];
    assign w_n[3] = r_d[2];

    generate
        for (genvar k = 0; k < 4; k++) begin : g_tap
`ifdef DECIM_ROUND_EN
            assign w_x[k] = {{(OUT_W-IN_W){w_n[k][IN_W-1]}}, w_n[k]};
`else
            // Bias negative samples by one so the shift truncates toward zero.
            logic signed [IN_W-1:0] w_half;
            assign w_half = (w_n[k] + $signed({{(IN_W-1){1'b0}}, w_n[k][IN_W-1]})) >>> 1;
            assign w_x[k] = {{(OUT_W-IN_W){w_half[IN_W-1]}}, w_half};
`endif
        end
    endgenerate

`ifdef DECIM_ROUND_EN
    localparam logic signed [OUT_W-1:0] c_ONE = 1;
    logic signed [OUT_W-1:0] w_sum;
    assign w_sum = w_x[0] - w_x[1] - w_x[2] + w_x[3];
    assign w_res = (w_sum + c_ONE) >>> 1;
`else
    assign w_res = w_x[0] - w_x[1] - w_x[2] + w_x[3];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) r_d[k] <= '0;
            r_phase     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
                for (int k = 0; k < 4; k++) r_d[k] <= w_n[k];
                if (sync) begin
                    // Sample starts a fresh frame; any pending output is dropped.
                    r_phase <= c_PH_ONE;
                end else if (r_phase == c_PH_LAST) begin
                    r_phase     <= '0;
                    r_out       <= w_res;
                    r_out_valid <= 1'b1;
                end else begin
                    r_phase <= r_phase + c_PH_ONE;
                end
            end else if (sync) begin
                r_phase <= '0;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign phase     = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_decim_fir.sv
`default_nettype none
// ============================================================================
// Module      : tb_decim_fir
// Description : Self-checking bench for decim_fir, DECIM=2 and DECIM=4 in parallel.
// Revision    : 1.0  initial release
// ============================================================================
module tb_decim_fir;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sync = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [14:0] xin = '0;

    logic               ov2, ov4;
    logic signed [17:0] out2, out4;
    logic [0:0]         ph2;
    logic [1:0]         ph4;

    int n_checks = 0;
    int n_errors = 0;
    int pulses2  = 0;
    int pulses4  = 0;

    decim_fir #(.IN_W(15), .OUT_W(18), .DECIM(2)) u_dut2 (
        .clk(clk), .rst(rst), .sync(sync), .in_valid(in_valid), .xin(xin),
        .out_valid(ov2), .out(out2), .phase(ph2)
    );

    decim_fir #(.IN_W(15), .OUT_W(18), .DECIM(4)) u_dut4 (
        .clk(clk), .rst(rst), .sync(sync), .in_valid(in_valid), .xin(xin),
        .out_valid(ov4), .out(out4), .phase(ph4)
    );

    always #5 clk = ~clk;

    // Reference: a history of accepted samples plus a count within the frame.
    int dec[2] = '{2, 4};
    int hist[2][4];
    int cnt[2];
    int mout[2];
    int mov[2];

    function automatic int filt(input int a0, input int a1, input int a2, input int a3);
`ifdef DECIM_ROUND_EN
        int s;
        s = a0 - a1 - a2 + a3;
        return (s + 1) >>> 1;
`else
        return a0 / 2 - a1 / 2 - a2 / 2 + a3 / 2;
`endif
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) hist[i][k] = 0;
                cnt[i]  = 0;
                mout[i] = 0;
                mov[i]  = 0;
            end else begin
                mov[i] = 0;
                if (in_valid) begin
                    for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
                    hist[i][0] = int'(xin);
                    if (sync) cnt[i] = 1;
                    else if (cnt[i] + 1 == dec[i]) begin
                        cnt[i]  = 0;
                        mov[i]  = 1;
                        mout[i] = filt(hist[i][0], hist[i][1], hist[i][2], hist[i][3]);
                    end else cnt[i] = cnt[i] + 1;
                end else if (sync) cnt[i] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit v, input int x);
        rst      = r;
        sync     = s;
        in_valid = v;
        xin      = x[14:0];
        @(posedge clk);
        model_edge();
        #1;
        if (ov2) pulses2++;
        if (ov4) pulses4++;
        check("out2", out2, mout[0]);
        check("ov2",  ov2,  mov[0]);
        check("ph2",  ph2,  cnt[0]);
        check("out4", out4, mout[1]);
        check("ov4",  ov4,  mov[1]);
        check("ph4",  ph4,  cnt[1]);
    endtask

    function automatic int rnd_x();
        return int'($urandom_range(0, 32767)) - 16384;
    endfunction

    initial begin
        // T1 reset with random activity on the other inputs
        for (int k = 0; k < 2; k++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_x());
        check("t1_out", out2, 0);
        check("t1_ov", ov2, 0);
        check("t1_ph4", ph4, 0);
        step(1'b0, 1'b0, 1'b0, 0);

        // T2 DECIM=2 basic frame
        pulses2 = 0;
        step(1'b0, 1'b0, 1'b1, 100);
        step(1'b0, 1'b0, 1'b1, 200);
        check("t2_ov_a", ov2, 1);
        check("t2_out_a", out2, 50);
        step(1'b0, 1'b0, 1'b1, 300);
        step(1'b0, 1'b0, 1'b1, 400);
        check("t2_out_b", out2, 0);
        check("t2_pulses", pulses2, 2);

        // T3 truncation / rounding of odd values
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 3);
`ifdef DECIM_ROUND_EN
        check("t3_pos", out2, 2);
`else
        check("t3_pos", out2, 1);
`endif
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, -3);
        check("t3_neg", out2, -1);

        // T4 extremes
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 16383);
        step(1'b0, 1'b0, 1'b1, -16384);
        step(1'b0, 1'b0, 1'b1, -16384);
        step(1'b0, 1'b0, 1'b1, 16383);
`ifdef DECIM_ROUND_EN
        check("t4_max", out2, 32767);
`else
        check("t4_max", out2, 32766);
`endif
        step(1'b0, 1'b0, 1'b1, -16384);
        step(1'b0, 1'b0, 1'b1, 16383);
        step(1'b0, 1'b0, 1'b1, 16383);
        step(1'b0, 1'b0, 1'b1, -16384);
`ifdef DECIM_ROUND_EN
        check("t4_min", out2, -32767);
`else
        check("t4_min", out2, -32766);
`endif

        // T5 gapped input, then sync
        step(1'b1, 1'b0, 1'b0, 0);
        pulses2 = 0;
        pulses4 = 0;
        for (int k = 0; k < 16; k++) step(1'b0, 1'b0, 1'((k % 2) == 0), rnd_x());
        check("t5_pulses4", pulses4, 2);
        check("t5_pulses2", pulses2, 4);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 40);
        step(1'b0, 1'b1, 1'b1, 6);
        check("t5_sync_ov", ov2, 0);
        check("t5_sync_ph", ph2, 1);
        step(1'b0, 1'b0, 1'b1, 100);
        check("t5_keep_ov", ov2, 1);
        check("t5_keep_out", out2, 27);
        step(1'b0, 1'b1, 1'b0, 0);
        check("t5_sync_idle", ph4, 0);

        // T6 reset mid-frame
        step(1'b0, 1'b0, 1'b1, 1234);
        check("t6_pre_ph", ph2, 1);
        step(1'b1, 1'b0, 1'b0, 0);
        check("t6_rst_ph", ph2, 0);
        step(1'b0, 1'b0, 1'b1, 7);
        step(1'b0, 1'b0, 1'b1, 9);
        check("t6_out", out2, 1);

        // Randomized traffic against the reference
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 3) != 0), rnd_x());

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
